// File: rtl/icache_direct_pkg.sv
// Shared definitions for the direct-mapped instruction cache: default geometry,
// controller state encoding and a word-alignment helper.
package icache_direct_pkg;

  localparam int INDEX_BITS_DEFAULT = 4;
  localparam int ADDR_BITS_DEFAULT  = 18;

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the instruction cache: combinational read port,
// synchronous write port, valid bits cleared by asynchronous reset.
module icache_array
  import icache_direct_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_BITS_DEFAULT,
  parameter int TAG_BITS   = ADDR_BITS_DEFAULT - INDEX_BITS_DEFAULT - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [31:0]           rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [31:0]           wr_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic                valid_reg [LINES];
  logic [TAG_BITS-1:0] tag_mem   [LINES];
  logic [31:0]         data_mem  [LINES];

  // Only the valid bits need reset; stale tags/data are masked by valid=0.
  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_valid
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_reg[gi] <= 1'b0;
        end else if (wr_en && (wr_idx == INDEX_BITS'(gi))) begin
          valid_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_reg[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache between the fetch stage
// and the memory controller's instruction port.
module icache_direct
  import icache_direct_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_BITS_DEFAULT,
  parameter int ADDR_BITS  = ADDR_BITS_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_inst,
  output logic [31:0] resp_addr,
  output logic        mem_if_enable,
  output logic [31:0] mem_inst_addr,
  input  logic        mem_if_ready,
  input  logic [31:0] mem_inst
);

  localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - 2;

  state_t                state_reg, state_next;
  logic                  issued_reg, issued_next;
  logic                  mem_if_enable_reg, mem_if_enable_next;
  logic [31:0]           mem_inst_addr_reg, mem_inst_addr_next;
  logic [INDEX_BITS-1:0] miss_idx_reg, miss_idx_next;
  logic [TAG_BITS-1:0]   miss_tag_reg, miss_tag_next;
  logic                  resp_valid_reg, resp_valid_next;
  logic [31:0]           resp_inst_reg, resp_inst_next;
  logic [31:0]           resp_addr_reg, resp_addr_next;

  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [31:0]           rd_data;
  logic                  lookup_hit;
  logic                  fill;
  logic                  wr_en;

  assign req_idx    = req_addr[INDEX_BITS+1:2];
  assign req_tag    = req_addr[ADDR_BITS-1:INDEX_BITS+2];
  assign lookup_hit = rd_valid && (rd_tag == req_tag);

  icache_array #(
    .INDEX_BITS(INDEX_BITS),
    .TAG_BITS  (TAG_BITS)
  ) u_array (
    .clk     (clk_in),
    .rst     (rst_in),
    .rd_idx  (req_idx),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_idx  (miss_idx_reg),
    .wr_tag  (miss_tag_reg),
    .wr_data (mem_inst)
  );

  always_comb begin
    state_next         = state_reg;
    issued_next        = issued_reg;
    mem_if_enable_next = mem_if_enable_reg;
    mem_inst_addr_next = mem_inst_addr_reg;
    miss_idx_next      = miss_idx_reg;
    miss_tag_next      = miss_tag_reg;
    resp_valid_next    = resp_valid_reg;
    resp_inst_next     = resp_inst_reg;
    resp_addr_next     = resp_addr_reg;
    fill               = 1'b0;

    if (clear) begin
      // The memory controller flushes too, so an in-flight miss is dropped.
      state_next         = IDLE;
      mem_if_enable_next = 1'b0;
      issued_next        = 1'b0;
      resp_valid_next    = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          resp_valid_next = 1'b0;
          if (req_valid) begin
            if (lookup_hit) begin
              resp_valid_next = 1'b1;
              resp_inst_next  = rd_data;
              resp_addr_next  = word_align(req_addr);
            end else begin
              mem_if_enable_next = 1'b1;
              mem_inst_addr_next = word_align(req_addr);
              miss_idx_next      = req_idx;
              miss_tag_next      = req_tag;
              issued_next        = 1'b0;
              state_next         = MISS;
            end
          end
        end
        MISS: begin
          resp_valid_next = 1'b0;
          // The controller reports ready while idle, so its ready is only
          // trusted from the second MISS cycle on.
          if (!issued_reg) begin
            issued_next = 1'b1;
          end else if (mem_if_ready) begin
            fill               = 1'b1;
            resp_valid_next    = 1'b1;
            resp_inst_next     = mem_inst;
            resp_addr_next     = mem_inst_addr_reg;
            mem_if_enable_next = 1'b0;
            state_next         = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign wr_en = fill && rdy_in;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg         <= IDLE;
      issued_reg        <= 1'b0;
      mem_if_enable_reg <= 1'b0;
      mem_inst_addr_reg <= 32'd0;
      miss_idx_reg      <= '0;
      miss_tag_reg      <= '0;
      resp_valid_reg    <= 1'b0;
      resp_inst_reg     <= 32'd0;
      resp_addr_reg     <= 32'd0;
    end else if (rdy_in) begin
      state_reg         <= state_next;
      issued_reg        <= issued_next;
      mem_if_enable_reg <= mem_if_enable_next;
      mem_inst_addr_reg <= mem_inst_addr_next;
      miss_idx_reg      <= miss_idx_next;
      miss_tag_reg      <= miss_tag_next;
      resp_valid_reg    <= resp_valid_next;
      resp_inst_reg     <= resp_inst_next;
      resp_addr_reg     <= resp_addr_next;
    end
  end

  assign req_ready     = (state_reg == IDLE);
  assign resp_valid    = resp_valid_reg;
  assign resp_inst     = resp_inst_reg;
  assign resp_addr     = resp_addr_reg;
  assign mem_if_enable = mem_if_enable_reg;
  assign mem_inst_addr = mem_inst_addr_reg;

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: directed scenarios plus a randomized
// fetch stream checked against a line-level model of cache contents.
module tb_icache_direct;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_inst;
  logic [31:0] resp_addr;
  logic        mem_if_enable;
  logic [31:0] mem_inst_addr;
  logic        mem_if_ready;
  logic [31:0] mem_inst;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: which word address (bits [17:2]) each line holds, and its data.
  bit          mv [16];
  logic [11:0] mt [16];
  logic [31:0] md [16];

  always #5 clk_in = ~clk_in;

  icache_direct dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .clear        (clear),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_inst    (resp_inst),
    .resp_addr    (resp_addr),
    .mem_if_enable(mem_if_enable),
    .mem_inst_addr(mem_inst_addr),
    .mem_if_ready (mem_if_ready),
    .mem_inst     (mem_inst)
  );

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[17:2], a[17:2]} ^ 32'h5A5A_0F0F;
  endfunction

  // One fetch through the cache; the hit/miss expectation comes from the model.
  task automatic do_fetch(input logic [31:0] a, input logic [31:0] word,
                          input int delay, output bit was_miss);
    logic [3:0]  idx;
    logic [11:0] tag;
    logic [31:0] al;
    bit          exp_hit;
    idx = a[5:2];
    tag = a[17:6];
    al = {a[31:2], 2'b00};
    exp_hit = mv[idx] && (mt[idx] == tag);
    req_valid = 1'b1;
    req_addr = a;
    mem_if_ready = 1'b1;
    mem_inst = ~word;
    step();
    req_valid = 1'b0;
    was_miss = mem_if_enable;
    n_cmp++; if (mem_if_enable !== !exp_hit) begin $display("FAIL fetch_miss_flag addr=%h: got %b expected %b", a, mem_if_enable, !exp_hit); n_bad++; end
    if (exp_hit) begin
      n_cmp++; if (resp_valid !== 1'b1) begin $display("FAIL hit_valid addr=%h: got %b expected 1", a, resp_valid); n_bad++; end
      n_cmp++; if (resp_inst !== md[idx]) begin $display("FAIL hit_inst addr=%h: got %h expected %h", a, resp_inst, md[idx]); n_bad++; end
      n_cmp++; if (resp_addr !== al) begin $display("FAIL hit_addr: got %h expected %h", resp_addr, al); n_bad++; end
    end else begin
      n_cmp++; if (mem_inst_addr !== al) begin $display("FAIL miss_mem_addr: got %h expected %h", mem_inst_addr, al); n_bad++; end
      n_cmp++; if (resp_valid !== 1'b0) begin $display("FAIL miss_no_resp: got %b expected 0", resp_valid); n_bad++; end
      step();
      n_cmp++; if (resp_valid !== 1'b0 || mem_if_enable !== 1'b1) begin $display("FAIL miss_first_cycle: got valid=%b en=%b expected valid=0 en=1", resp_valid, mem_if_enable); n_bad++; end
      mem_if_ready = 1'b0;
      repeat (delay) step();
      mem_inst = word;
      mem_if_ready = 1'b1;
      step();
      n_cmp++; if (resp_valid !== 1'b1) begin $display("FAIL fill_valid addr=%h: got %b expected 1", a, resp_valid); n_bad++; end
      n_cmp++; if (resp_inst !== word) begin $display("FAIL fill_inst: got %h expected %h", resp_inst, word); n_bad++; end
      n_cmp++; if (resp_addr !== al) begin $display("FAIL fill_addr: got %h expected %h", resp_addr, al); n_bad++; end
      n_cmp++; if (mem_if_enable !== 1'b0) begin $display("FAIL fill_enable_drop: got %b expected 0", mem_if_enable); n_bad++; end
      mv[idx] = 1'b1;
      mt[idx] = tag;
      md[idx] = word;
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; req_valid = 1'b0;
    req_addr = 32'd0; mem_if_ready = 1'b1; mem_inst = 32'd0;
    foreach (mv[i]) mv[i] = 1'b0;
    step(); step();
    n_cmp++; if (req_ready !== 1'b1) begin $display("FAIL reset_req_ready: got %b expected 1", req_ready); n_bad++; end
    n_cmp++; if (resp_valid !== 1'b0) begin $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); n_bad++; end
    n_cmp++; if (resp_inst !== 32'd0 || resp_addr !== 32'd0) begin $display("FAIL reset_resp: got inst=%h addr=%h expected 0/0", resp_inst, resp_addr); n_bad++; end
    n_cmp++; if (mem_if_enable !== 1'b0 || mem_inst_addr !== 32'd0) begin $display("FAIL reset_mem: got en=%b addr=%h expected 0/0", mem_if_enable, mem_inst_addr); n_bad++; end
    @(negedge clk_in);
    rst_in = 1'b0;
    step();
  endtask

  task automatic test_cold_miss();
    bit m;
    do_fetch(32'h0000_1004, 32'h00A0_0093, 1, m);
    n_cmp++; if (m !== 1'b1) begin $display("FAIL cold_miss: got miss=%b expected 1", m); n_bad++; end
  endtask

  task automatic test_hit_stream();
    req_valid = 1'b1;
    req_addr = 32'h0000_1004;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (resp_valid !== 1'b1 || resp_inst !== 32'h00A0_0093 || resp_addr !== 32'h0000_1004) begin $display("FAIL hit_stream[%0d]: got v=%b inst=%h addr=%h expected 1/00a00093/00001004", i, resp_valid, resp_inst, resp_addr); n_bad++; end
      n_cmp++; if (mem_if_enable !== 1'b0) begin $display("FAIL hit_stream_enable[%0d]: got %b expected 0", i, mem_if_enable); n_bad++; end
    end
    req_valid = 1'b0;
    step();
    n_cmp++; if (resp_valid !== 1'b0) begin $display("FAIL hit_stream_pulse: got %b expected 0", resp_valid); n_bad++; end
  endtask

  task automatic test_conflict();
    bit m;
    do_fetch(32'h0000_1044, 32'h1234_5678, 2, m);
    n_cmp++; if (m !== 1'b1) begin $display("FAIL conflict_miss: got miss=%b expected 1", m); n_bad++; end
    do_fetch(32'h0000_1004, 32'h00A0_0093, 0, m);
    n_cmp++; if (m !== 1'b1) begin $display("FAIL evicted_miss: got miss=%b expected 1", m); n_bad++; end
    do_fetch(32'h0000_1004, 32'h0, 0, m);
    n_cmp++; if (m !== 1'b0) begin $display("FAIL refill_hit: got miss=%b expected 0", m); n_bad++; end
  endtask

  task automatic test_clear_mid_miss();
    bit m;
    req_valid = 1'b1; req_addr = 32'h0000_2000; mem_if_ready = 1'b1; mem_inst = 32'hBAD0_BAD0;
    step();
    req_valid = 1'b0;
    n_cmp++; if (mem_if_enable !== 1'b1) begin $display("FAIL clear_setup_miss: got %b expected 1", mem_if_enable); n_bad++; end
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_cmp++; if (mem_if_enable !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin $display("FAIL clear_abort: got en=%b v=%b rdy=%b expected 0/0/1", mem_if_enable, resp_valid, req_ready); n_bad++; end
    step();
    n_cmp++; if (resp_valid !== 1'b0) begin $display("FAIL clear_no_resp: got %b expected 0", resp_valid); n_bad++; end
    do_fetch(32'h0000_2000, 32'h2222_0000, 0, m);
    n_cmp++; if (m !== 1'b1) begin $display("FAIL clear_remiss: got miss=%b expected 1", m); n_bad++; end
  endtask

  task automatic test_stall();
    bit m;
    req_valid = 1'b1; req_addr = 32'h0000_3008; mem_if_ready = 1'b0;
    step();
    req_valid = 1'b0;
    step();
    rdy_in = 1'b0; mem_if_ready = 1'b1; mem_inst = 32'hCAFE_F00D;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (mem_if_enable !== 1'b1 || resp_valid !== 1'b0 || req_ready !== 1'b0 || mem_inst_addr !== 32'h0000_3008) begin $display("FAIL stall_hold[%0d]: got en=%b v=%b rdy=%b addr=%h expected 1/0/0/00003008", i, mem_if_enable, resp_valid, req_ready, mem_inst_addr); n_bad++; end
    end
    rdy_in = 1'b1;
    step();
    n_cmp++; if (resp_valid !== 1'b1 || resp_inst !== 32'hCAFE_F00D || resp_addr !== 32'h0000_3008) begin $display("FAIL stall_fill: got v=%b inst=%h addr=%h expected 1/cafef00d/00003008", resp_valid, resp_inst, resp_addr); n_bad++; end
    mv[2] = 1'b1; mt[2] = 12'h0C0; md[2] = 32'hCAFE_F00D;
    rdy_in = 1'b0;
    step(); step();
    n_cmp++; if (resp_valid !== 1'b1) begin $display("FAIL stall_resp_hold: got %b expected 1", resp_valid); n_bad++; end
    rdy_in = 1'b1;
    step();
    n_cmp++; if (resp_valid !== 1'b0) begin $display("FAIL stall_resp_drop: got %b expected 0", resp_valid); n_bad++; end
    do_fetch(32'h0000_3008, 32'h0, 0, m);
    n_cmp++; if (m !== 1'b0) begin $display("FAIL stall_then_hit: got miss=%b expected 0", m); n_bad++; end
  endtask

  task automatic test_random();
    logic [11:0] tags [3];
    logic [31:0] r;
    logic [31:0] a;
    logic [3:0]  idx;
    bit          m;
    tags[0] = 12'h040; tags[1] = 12'h041; tags[2] = 12'h7FF;
    for (int i = 0; i < 80; i++) begin
      r = $urandom();
      idx = 4'($urandom_range(0, 15));
      a = {r[31:18], tags[$urandom_range(0, 2)], idx, r[1:0]};
      do_fetch(a, mem_word(a), int'($urandom_range(0, 3)), m);
    end
  endtask

  task automatic test_async_reset();
    bit m;
    req_valid = 1'b1; req_addr = 32'h0000_5000; mem_if_ready = 1'b1;
    step();
    req_valid = 1'b0;
    n_cmp++; if (mem_if_enable !== 1'b1) begin $display("FAIL areset_setup_miss: got %b expected 1", mem_if_enable); n_bad++; end
    #2 rst_in = 1'b1;
    #1;
    n_cmp++; if (mem_if_enable !== 1'b0 || req_ready !== 1'b1 || mem_inst_addr !== 32'd0) begin $display("FAIL areset_immediate: got en=%b rdy=%b addr=%h expected 0/1/0", mem_if_enable, req_ready, mem_inst_addr); n_bad++; end
    step();
    #2 rst_in = 1'b0;
    foreach (mv[i]) mv[i] = 1'b0;
    step();
    do_fetch(32'h0000_1004, 32'h00A0_0093, 1, m);
    n_cmp++; if (m !== 1'b1) begin $display("FAIL areset_remiss: got miss=%b expected 1", m); n_bad++; end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit_stream();
    test_conflict();
    test_clear_mid_miss();
    test_stall();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, one-word-per-line instruction cache between the fetch stage and memctrl's instruction port.
- Hits return a registered instruction one cycle after the request, so back-to-back hits sustain one instruction per cycle.
- Misses drive memctrl's if_enable/inst_addr handshake, fill the line, and forward the fetched word.

Parameters:
INDEX_BITS, 4, log2 of line count (16 lines)
ADDR_BITS, 18, significant address bits; tag = addr[ADDR_BITS-1:INDEX_BITS+2]

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, asynchronous, active-high
rdy_in  input  1  global stall; low freezes all state
clear  input  1  pipeline flush (synchronous, qualified by rdy_in)
req_valid  input  1  fetch stage presents an address
req_addr  input  32  instruction address; bits [1:0] ignored
req_ready  output  1  request accepted this cycle when req_valid && req_ready
resp_valid  output  1  one-cycle pulse, resp_inst valid
resp_inst  output  32  instruction word
resp_addr  output  32  address of resp_inst (word aligned)
mem_if_enable  output  1  to memctrl if_enable
mem_inst_addr  output  32  to memctrl inst_addr (word aligned)
mem_if_ready  input  1  from memctrl if_ready
mem_inst  input  32  from memctrl inst

Behaviour:
- Reset (async, rst_in=1): all valid bits 0, state IDLE, req_ready=1, resp_valid=0, resp_inst=0, resp_addr=0, mem_if_enable=0, mem_inst_addr=0. Tag/data arrays need no reset.
- All updates happen on posedge clk_in only when rdy_in=1. With rdy_in=0, registers hold and resp_valid holds its value.
- req_ready = (state==IDLE), combinational from state.
- States:
  - IDLE, on accepted request with hit (valid[idx] && tag[idx]==tag): next cycle resp_valid=1, resp_inst=data[idx], resp_addr={req_addr[31:2],2'b00}. Stay IDLE.
  - IDLE, on accepted request with miss: mem_if_enable<=1, mem_inst_addr<={req_addr[31:2],2'b00}, latch idx/tag/addr, issued<=0, go to MISS. resp_valid<=0.
  - IDLE, no request: resp_valid<=0.
  - MISS, first cycle (issued=0): set issued<=1. Ignore mem_if_ready here, because memctrl reports ready while idle before it has started.
  - MISS, issued=1 && mem_if_ready=1: write data[idx]=mem_inst, tag[idx]=latched tag, valid[idx]=1. Next cycle resp_valid=1, resp_inst=mem_inst, resp_addr=latched addr. mem_if_enable<=0, go to IDLE.
- mem_if_enable stays high for the whole MISS state. mem_inst_addr is stable throughout.
- clear=1 (with rdy_in): state<=IDLE, mem_if_enable<=0, issued<=0, resp_valid<=0. No fill from the aborted miss, since memctrl also resets on clear. Valid/tag/data arrays are kept. clear overrides any simultaneous request, hit or fill.
- Reset during MISS: no array write. Outputs go to reset values immediately (asynchronous).
- A request at the same index as a just-filled line in the following cycle must hit. The fill is visible to a lookup one cycle after the write.
- Address bits above ADDR_BITS are ignored for tag compare.
- resp_valid is never high for two cycles from one request. The fetch stage must accept resp without backpressure.

Decomposition:
- Shared package: INDEX_BITS/ADDR_BITS defaults, state encoding (IDLE=0, MISS=1).
- One sub-module is natural: icache_array (valid/tag/data storage). It has a combinational read port, a synchronous write port, and valid-bit clear on async reset.
- FSM and handshakes stay in icache_direct.

Test Plan:
- Cold miss: reset, req 0x0000_1004. Expect mem_if_enable=1 with mem_inst_addr=0x1004 next cycle, mem_if_ready ignored in the first MISS cycle. Memctrl returns 0x00A00093 → resp_valid=1, resp_inst=0x00A00093, resp_addr=0x1004, mem_if_enable=0.
- Hit stream: after the fill, requests 0x1004 on 3 consecutive cycles. Expect resp_valid=1 on each following cycle with 0x00A00093, and mem_if_enable never asserted.
- Conflict: 0x1004 cached. req 0x1044 (same idx, different tag) → miss, fill 0x12345678. Then req 0x1004 → miss again (line evicted).
- Clear mid-miss: req 0x2000 misses, clear=1 in the second MISS cycle. Expect mem_if_enable=0 next cycle, no resp_valid. A later req 0x2000 misses again.
- Stall: hold rdy_in=0 for 5 cycles during MISS with mem_if_ready=1. Expect no state change. The fill completes after rdy_in returns high.
- Async reset: assert rst_in between clock edges during MISS. Expect mem_if_enable=0 and req_ready=1 immediately, and 0x1004 misses afterwards.
